// File: rtl/cnt_uart_pkg.sv
// Shared definitions for the frame-counter UART reporter: packet layout constants,
// sequencer states and the packet byte selector.
package cnt_uart_pkg;

    localparam logic [7:0]  HDR_BYTE      = 8'hA5;
    localparam int unsigned PKT_BYTES     = 6;
    localparam int unsigned BITS_PER_BYTE = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StData,
        StStop
    } seq_state_e;

    // Byte idx of the packet: header, counter MSB..LSB, then the XOR checksum.
    function automatic logic [7:0] pkt_byte(input logic [2:0] idx, input logic [31:0] snap);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HDR_BYTE;
            3'd1:    b = snap[31:24];
            3'd2:    b = snap[23:16];
            3'd3:    b = snap[15:8];
            3'd4:    b = snap[7:0];
            default: b = snap[31:24] ^ snap[23:16] ^ snap[15:8] ^ snap[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A load during the last stop-bit cycle chains the next byte
// with no idle gap; done flags that last cycle.
module uart_tx_byte
    import cnt_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       load,
    output logic       txd,
    output logic       done
);

    localparam int unsigned     CntW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    seq_state_e      phase_q, phase_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
    logic            bit_end;

    assign bit_end = (bit_cnt_q == CntLast);
    assign done    = (phase_q == StStop) && bit_end;
    assign txd     = txd_q;

    always_comb begin
        phase_d   = phase_q;
        bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (phase_q)
            StStart: begin
                if (bit_end) begin
                    phase_d   = StData;
                    bit_idx_d = '0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        phase_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (bit_end) phase_d = StIdle;
            end
            default: begin
                phase_d   = StIdle;
                bit_cnt_d = '0;
            end
        endcase
        if (load) begin
            phase_d   = StStart;
            bit_cnt_d = '0;
            bit_idx_d = '0;
            shift_d   = data;
        end
        // Line level is registered from the next state so it changes exactly on bit edges.
        case (phase_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

endmodule

// File: rtl/cnt_uart_reporter.sv
// Snapshots the 32-bit frame counter and sends it as a 6-byte UART packet,
// periodically and on request; triggers during a packet collapse into one pending report.
module cnt_uart_reporter
    import cnt_uart_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 868,
    parameter int unsigned REPORT_PERIOD = 100_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cnt1,
    input  logic [7:0] cnt2,
    input  logic [7:0] cnt3,
    input  logic [7:0] cnt4,
    input  logic       start,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned     PerW    = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
    localparam logic [PerW-1:0] PerLast = PerW'(REPORT_PERIOD - 1);

    seq_state_e      state_q, state_d;
    logic [PerW-1:0] period_q;
    logic [31:0]     snap_q, snap_d;
    logic [2:0]      byte_idx_q, byte_idx_d, load_idx;
    logic            busy_q, busy_d;
    logic            pending_q, pending_d;
    logic            frame_done_q, frame_done_d;
    logic            tick, trigger, tx_load, tx_done;

    assign tick       = (period_q == PerLast);
    assign trigger    = start | tick;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        byte_idx_d   = byte_idx_q;
        busy_d       = busy_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;
        tx_load      = 1'b0;
        load_idx     = byte_idx_q;
        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    snap_d     = {cnt4, cnt3, cnt2, cnt1};
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                tx_load  = 1'b1;
                load_idx = '0;
                state_d  = StData;
                if (trigger) pending_d = 1'b1;
            end
            StData: begin
                if (trigger) pending_d = 1'b1;
                if (tx_done) begin
                    if (byte_idx_q != 3'(PKT_BYTES - 1)) begin
                        tx_load    = 1'b1;
                        load_idx   = byte_idx_q + 3'd1;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end else begin
                        frame_done_d = 1'b1;
                        byte_idx_d   = '0;
                        // A trigger on this very edge still finds busy high, so it chains too.
                        if (pending_q || trigger) begin
                            pending_d = 1'b0;
                            snap_d    = {cnt4, cnt3, cnt2, cnt1};
                            state_d   = StLoad;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            period_q     <= '0;
            snap_q       <= '0;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= tick ? '0 : period_q + 1'b1;
            snap_q       <= snap_d;
            byte_idx_q   <= byte_idx_d;
            busy_q       <= busy_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    uart_tx_byte #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk  (clk),
        .rst_n(rst_n),
        .data (pkt_byte(load_idx, snap_q)),
        .load (tx_load),
        .txd  (txd),
        .done (tx_done)
    );

endmodule

// File: tb/tb_cnt_uart_reporter.sv
// Directed bench: an independent UART receiver on txd decodes packets while one
// initial block drives stimulus and asserts hand-computed expectations.
module tb_cnt_uart_reporter;

    localparam int Div     = 4;
    localparam int Period  = 1000;
    localparam int BitMid  = Div / 2;
    localparam int ByteLen = 10 * Div;
    localparam int LastOff = 59 * Div + Div / 2;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cnt1  = 8'h00;
    logic [7:0] cnt2  = 8'h00;
    logic [7:0] cnt3  = 8'h00;
    logic [7:0] cnt4  = 8'h00;
    logic       start = 1'b0;
    logic       txd, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    cnt_uart_reporter #(
        .CLK_DIV      (Div),
        .REPORT_PERIOD(Period)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
        .cnt4      (cnt4),
        .start     (start),
        .txd       (txd),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: samples txd mid-bit on falling edges.
    logic       in_pkt        = 1'b0;
    int         pkt_start_cyc = 0;
    int         start_count   = 0;
    int         pkt_count     = 0;
    int         fd_count      = 0;
    int         fd_cyc        = 0;
    int         busy_low      = 0;
    int         frame_err     = 0;
    logic [7:0] cur_byte      = 8'h00;
    logic [7:0] rx [6];
    int         pkt_off, mon_bit, mon_byte;

    assign pkt_off  = cyc - pkt_start_cyc;
    assign mon_bit  = (pkt_off % ByteLen) / Div;
    assign mon_byte = pkt_off / ByteLen;

    always @(negedge clk) begin
        if (frame_done === 1'b1) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
        end
        if (busy !== 1'b1) busy_low <= busy_low + 1;
        if (rst_n !== 1'b1) begin
            in_pkt <= 1'b0;
        end else if (!in_pkt) begin
            if (txd === 1'b0) begin
                in_pkt        <= 1'b1;
                pkt_start_cyc <= cyc;
                start_count   <= start_count + 1;
            end
        end else if (pkt_off % Div == BitMid) begin
            if (mon_bit == 0 && txd !== 1'b0) frame_err <= frame_err + 1;
            if (mon_bit == 9 && txd !== 1'b1) frame_err <= frame_err + 1;
            if (mon_bit >= 1 && mon_bit <= 8) cur_byte[3'(mon_bit - 1)] <= txd;
            if (mon_bit == 9) rx[3'(mon_byte)] <= cur_byte;
            if (pkt_off == LastOff) begin
                in_pkt    <= 1'b0;
                pkt_count <= pkt_count + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [47:0] exp);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s byte%0d", tag, i), {24'h0, rx[i]}, {24'h0, exp[47-8*i -: 8]});
        end
    endtask

    task automatic wait_pkts(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (pkt_count < target && n < budget) begin
            step();
            n++;
        end
        check({tag, " arrived"}, {31'h0, pkt_count >= target}, 32'd1);
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        s     = cyc + 1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset(output int r);
        rst_n = 1'b0;
        repeat (10) step();
        rst_n = 1'b1;
        r     = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, s, s2, bl, base_pkt, base_fd, base_start;

        // Reset held from time zero
        for (int i = 0; i < 10; i++) begin
            step();
            check("reset txd", {31'h0, txd}, 32'd1);
            check("reset busy", {31'h0, busy}, 32'd0);
        end
        rst_n = 1'b1;
        r     = cyc;

        // Periodic reports only
        wait_until(r + Period);
        check("no early start bit", start_count, 0);
        wait_pkts(1, 400, "periodic 1");
        check("periodic 1 start", pkt_start_cyc, r + 1001);
        check_bytes("periodic 1", 48'hA5_00_00_00_00_00);
        wait_pkts(2, 1200, "periodic 2");
        check("periodic 2 start", pkt_start_cyc, r + 2001);
        wait_pkts(3, 1200, "periodic 3");
        check("periodic 3 start", pkt_start_cyc, r + 3001);
        repeat (5) step();
        check("periodic frame_done count", fd_count, 3);

        // Single on-demand report
        do_reset(r);
        cnt4 = 8'h12; cnt3 = 8'h34; cnt2 = 8'h56; cnt1 = 8'h78;
        wait_until(r + 20);
        base_pkt = pkt_count;
        base_fd  = fd_count;
        pulse_start(s);
        check("single busy rise", {31'h0, busy}, 32'd1);
        wait_pkts(base_pkt + 1, 400, "single");
        repeat (5) step();
        check("single start latency", pkt_start_cyc, s + 1);
        check_bytes("single", 48'hA5_12_34_56_78_08);
        check("single frame_done time", fd_cyc, s + 241);
        check("single frame_done count", fd_count, base_fd + 1);
        check("single busy after", {31'h0, busy}, 32'd0);
        check("single txd idle", {31'h0, txd}, 32'd1);

        // Inputs change mid-packet
        wait_until(r + 300);
        base_pkt = pkt_count;
        pulse_start(s);
        wait_until(s + 51);
        cnt4 = 8'hFF; cnt3 = 8'hFF; cnt2 = 8'hFF; cnt1 = 8'hFF;
        wait_pkts(base_pkt + 1, 400, "coherent");
        repeat (5) step();
        check("coherent start", pkt_start_cyc, s + 1);
        check_bytes("coherent", 48'hA5_12_34_56_78_08);
        check("coherent frame_done time", fd_cyc, s + 241);

        // Several triggers during a packet collapse into one chained packet
        do_reset(r);
        cnt4 = 8'h01; cnt3 = 8'h02; cnt2 = 8'h03; cnt1 = 8'h04;
        wait_until(r + 20);
        base_pkt = pkt_count;
        base_fd  = fd_count;
        pulse_start(s);
        bl = busy_low;
        wait_until(s + 30);
        pulse_start(s2);
        wait_until(s + 100);
        pulse_start(s2);
        wait_until(s + 200);
        pulse_start(s2);
        wait_until(s + 210);
        cnt4 = 8'h11; cnt3 = 8'h22; cnt2 = 8'h33; cnt1 = 8'h44;
        wait_pkts(base_pkt + 1, 400, "chain first");
        check_bytes("chain first", 48'hA5_01_02_03_04_04);
        wait_until(s + 243);
        check("chain first frame_done", fd_cyc, s + 241);
        wait_pkts(base_pkt + 2, 400, "chain second");
        check("chain second start", pkt_start_cyc, s + 242);
        check("chain busy held", busy_low, bl);
        check_bytes("chain second", 48'hA5_11_22_33_44_44);
        wait_until(s + 800);
        check("chain packet count", pkt_count, base_pkt + 2);
        check("chain frame_done count", fd_count, base_fd + 2);
        check("chain busy after", {31'h0, busy}, 32'd0);

        // Reset mid-packet with a trigger pending
        do_reset(r);
        wait_until(r + 20);
        base_fd    = fd_count;
        base_start = start_count;
        pulse_start(s);
        wait_until(s + 50);
        pulse_start(s2);
        wait_until(s + 100);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort txd", {31'h0, txd}, 32'd1);
            check("abort busy", {31'h0, busy}, 32'd0);
        end
        rst_n = 1'b1;
        r     = cyc;
        wait_until(r + 600);
        check("abort no frame_done", fd_count, base_fd);
        check("abort no new packet", start_count, base_start + 1);
        check("abort busy idle", {31'h0, busy}, 32'd0);

        check("framing errors", frame_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
